// File: rtl/pe_sched_pkg.sv
// Shared constants and types for the PE reducer scheduler.
// Holds widths, lane count, watchdog limit, the FSM state enum and the 3-coordinate address.
package pe_sched_pkg;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 16;
    localparam int CNT_W     = 16;
    localparam int LANES     = 3;
    localparam int FINISH_TO = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Coordinate c0 occupies the least significant bits of a packed address.
    typedef struct packed {
        logic [ADDR_W-1:0] c2;
        logic [ADDR_W-1:0] c1;
        logic [ADDR_W-1:0] c0;
    } addr3_t;

endpackage

// File: rtl/pe_triple_buf.sv
// Three-lane capture buffer feeding the reducer.
// On an early last entry, the remaining lanes get zero data and repeat the last valid address.
module pe_triple_buf
    import pe_sched_pkg::*;
#(
    parameter int ADDR_W = pe_sched_pkg::ADDR_W,
    parameter int DATA_W = pe_sched_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [1:0]                    slot,
    input  logic                          last,
    input  logic [3*ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]             w,
    input  logic [DATA_W-1:0]             ia,
    output logic [LANES*3*ADDR_W-1:0]     lane_addr,
    output logic [LANES*DATA_W-1:0]       lane_w,
    output logic [LANES*DATA_W-1:0]       lane_ia
);

    logic [3*ADDR_W-1:0] addr_q [LANES];
    logic [DATA_W-1:0]   w_q    [LANES];
    logic [DATA_W-1:0]   ia_q   [LANES];

    // Lanes only change on an accepted entry, so they hold steady while the reducer works.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                addr_q[i] <= '0;
                w_q[i]    <= '0;
                ia_q[i]   <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (i == int'(slot)) begin
                    addr_q[i] <= addr;
                    w_q[i]    <= w;
                    ia_q[i]   <= ia;
                end else if (last && (i > int'(slot))) begin
                    addr_q[i] <= addr;
                    w_q[i]    <= '0;
                    ia_q[i]   <= '0;
                end
            end
        end
    end

    always_comb begin
        lane_addr = '0;
        lane_w    = '0;
        lane_ia   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_addr[i*3*ADDR_W +: 3*ADDR_W] = addr_q[i];
            lane_w[i*DATA_W +: DATA_W]        = w_q[i];
            lane_ia[i*DATA_W +: DATA_W]       = ia_q[i];
        end
    end

endmodule

// File: rtl/pe_reducer_sched.sv
// Groups incoming entries into triples and hands each triple to the reducer.
// Optional WAIT watchdog enabled by defining PE_SCHED_TIMEOUT_EN.
module pe_reducer_sched
    import pe_sched_pkg::*;
#(
    parameter int ADDR_W    = pe_sched_pkg::ADDR_W,
    parameter int DATA_W    = pe_sched_pkg::DATA_W,
    parameter int CNT_W     = pe_sched_pkg::CNT_W,
    parameter int FINISH_TO = pe_sched_pkg::FINISH_TO
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [3*ADDR_W-1:0]           i_in_addr,
    input  logic [DATA_W-1:0]             i_in_w,
    input  logic [DATA_W-1:0]             i_in_ia,
    input  logic                          i_in_last,
    output logic                          o_pe_start,
    output logic [LANES*3*ADDR_W-1:0]     o_pe_addr,
    output logic [LANES*DATA_W-1:0]       o_pe_w,
    output logic [LANES*DATA_W-1:0]       o_pe_ia,
    input  logic                          i_pe_finish,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [CNT_W-1:0]              o_triple_cnt,
    output logic                          o_err
);

    state_t           state, next_state;
    logic [1:0]       slot_cnt;
    logic [1:0]       wr_slot;
    logic             last_seen;
    logic [CNT_W-1:0] triple_cnt;
    logic             accept;
    logic             finish_eff;

    assign accept       = i_in_valid && o_in_ready;
    assign wr_slot      = (state == S_IDLE) ? 2'd0 : slot_cnt;
    assign o_triple_cnt = triple_cnt;

`ifdef PE_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(FINISH_TO + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout;
    logic            err_q;

    assign timeout    = (state == S_WAIT) && (wd_cnt == WD_W'(FINISH_TO - 1));
    assign finish_eff = i_pe_finish || timeout;
    assign o_err      = err_q;

    // A timeout counts as a finish, so a silent reducer cannot stall the frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == S_WAIT) ? wd_cnt + 1'b1 : '0;
            if (timeout && !i_pe_finish)
                err_q <= 1'b1;
        end
    end
`else
    assign finish_eff = i_pe_finish;
    assign o_err      = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        o_in_ready = 1'b0;
        o_pe_start = 1'b0;
        o_done     = 1'b0;
        o_busy     = 1'b1;
        case (state)
            S_IDLE: begin
                o_busy     = 1'b0;
                o_in_ready = 1'b1;
                if (i_in_valid)
                    next_state = i_in_last ? S_ISSUE : S_FILL;
            end
            S_FILL: begin
                o_in_ready = 1'b1;
                if (i_in_valid && (slot_cnt == 2'd2 || i_in_last))
                    next_state = S_ISSUE;
            end
            S_ISSUE: begin
                o_pe_start = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                if (finish_eff)
                    next_state = last_seen ? S_DONE : S_FILL;
            end
            S_DONE: begin
                o_done     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // The triple count survives DONE and IDLE; only the next frame's first accept clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_cnt   <= 2'd0;
            last_seen  <= 1'b0;
            triple_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        slot_cnt   <= 2'd1;
                        last_seen  <= i_in_last;
                        triple_cnt <= '0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        slot_cnt  <= slot_cnt + 2'd1;
                        last_seen <= i_in_last;
                    end
                end
                S_ISSUE: triple_cnt <= triple_cnt + 1'b1;
                S_WAIT: begin
                    if (finish_eff)
                        slot_cnt <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    pe_triple_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (i_clk),
        .rst       (i_rst),
        .wr_en     (accept),
        .slot      (wr_slot),
        .last      (i_in_last),
        .addr      (i_in_addr),
        .w         (i_in_w),
        .ia        (i_in_ia),
        .lane_addr (o_pe_addr),
        .lane_w    (o_pe_w),
        .lane_ia   (o_pe_ia)
    );

endmodule

// File: tb/tb_pe_reducer_sched.sv
// Directed, cycle-accurate bench for pe_reducer_sched: a vector table plus hand-written corner sequences.
// The watchdog sequence is built only when PE_SCHED_TIMEOUT_EN is defined.
module tb_pe_reducer_sched;
    import pe_sched_pkg::*;

    localparam int AW = 3 * ADDR_W;
    localparam int LW = AW + 2 * DATA_W;

    logic                     i_clk;
    logic                     i_rst;
    logic                     i_in_valid;
    logic                     o_in_ready;
    logic [AW-1:0]            i_in_addr;
    logic [DATA_W-1:0]        i_in_w;
    logic [DATA_W-1:0]        i_in_ia;
    logic                     i_in_last;
    logic                     o_pe_start;
    logic [LANES*AW-1:0]      o_pe_addr;
    logic [LANES*DATA_W-1:0]  o_pe_w;
    logic [LANES*DATA_W-1:0]  o_pe_ia;
    logic                     i_pe_finish;
    logic                     o_busy;
    logic                     o_done;
    logic [CNT_W-1:0]         o_triple_cnt;
    logic                     o_err;

    int errors = 0;
    int checks = 0;

    pe_reducer_sched dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_addr    (i_in_addr),
        .i_in_w       (i_in_w),
        .i_in_ia      (i_in_ia),
        .i_in_last    (i_in_last),
        .o_pe_start   (o_pe_start),
        .o_pe_addr    (o_pe_addr),
        .o_pe_w       (o_pe_w),
        .o_pe_ia      (o_pe_ia),
        .i_pe_finish  (i_pe_finish),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_triple_cnt (o_triple_cnt),
        .o_err        (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic             valid;
        logic             last;
        logic             finish;
        int               ent;
        logic             exp_ready;
        logic             exp_start;
        logic             exp_done;
        logic             exp_busy;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [AW-1:0] mk_addr(input int x, input int y, input int z);
        addr3_t a;
        a.c0 = ADDR_W'(x);
        a.c1 = ADDR_W'(y);
        a.c2 = ADDR_W'(z);
        return a;
    endfunction

    function automatic logic [AW-1:0] ent_addr(input int k);
        return mk_addr(k + 1, k + 10, k + 20);
    endfunction

    function automatic logic [DATA_W-1:0] ent_w(input int k);
        return DATA_W'(100 + 7 * k);
    endfunction

    function automatic logic [DATA_W-1:0] ent_ia(input int k);
        return DATA_W'(16'hF000 + 3 * k);
    endfunction

    function automatic vec_t mk_vec(input logic v, input logic l, input logic f, input int k,
                                    input logic r, input logic s, input logic d, input logic b,
                                    input int c);
        vec_t t;
        t.valid = v; t.last = l; t.finish = f; t.ent = k;
        t.exp_ready = r; t.exp_start = s; t.exp_done = d; t.exp_busy = b;
        t.exp_cnt = CNT_W'(c);
        return t;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [AW-1:0] addr,
                                  input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] ia,
                                  input logic last, input logic finish);
        i_in_valid  = valid;
        i_in_addr   = addr;
        i_in_w      = w;
        i_in_ia     = ia;
        i_in_last   = last;
        i_pe_finish = finish;
    endtask

    task automatic send_ent(input int k, input logic last);
        apply_stimulus(1'b1, ent_addr(k), ent_w(k), ent_ia(k), last, 1'b0);
    endtask

    task automatic idle_inputs();
        apply_stimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic pulse_finish();
        apply_stimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic check_output(input string name, input logic r, input logic s, input logic d,
                                input logic b, input logic e, input logic [CNT_W-1:0] c);
        logic [CNT_W+4:0] act, exp;
        act = {o_in_ready, o_pe_start, o_done, o_busy, o_err, o_triple_cnt};
        exp = {r, s, d, b, e, c};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got ready/start/done/busy/err=%b%b%b%b%b cnt=%0d, want %b%b%b%b%b cnt=%0d",
                     name, o_in_ready, o_pe_start, o_done, o_busy, o_err, o_triple_cnt,
                     r, s, d, b, e, c);
        end
    endtask

    task automatic check_lane(input string name, input int lane, input logic [AW-1:0] a,
                              input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] ia);
        logic [LW-1:0] act, exp;
        act = {o_pe_addr[lane*AW +: AW], o_pe_w[lane*DATA_W +: DATA_W], o_pe_ia[lane*DATA_W +: DATA_W]};
        exp = {a, w, ia};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s lane%0d: got addr/w/ia=%h, want %h", name, lane, act, exp);
        end
    endtask

    task automatic check_lane_ent(input string name, input int lane, input int k);
        check_lane(name, lane, ent_addr(k), ent_w(k), ent_ia(k));
    endtask

    initial begin
        // Six entries, last on the sixth; finish arrives two cycles after each start.
        vecs[0]  = mk_vec(1, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[1]  = mk_vec(1, 0, 0, 1, 1, 0, 0, 1, 0);
        vecs[2]  = mk_vec(1, 0, 0, 2, 1, 0, 0, 1, 0);
        vecs[3]  = mk_vec(0, 0, 0, 0, 0, 1, 0, 1, 0);
        vecs[4]  = mk_vec(0, 0, 0, 0, 0, 0, 0, 1, 1);
        vecs[5]  = mk_vec(0, 0, 1, 0, 0, 0, 0, 1, 1);
        vecs[6]  = mk_vec(1, 0, 0, 3, 1, 0, 0, 1, 1);
        vecs[7]  = mk_vec(1, 0, 0, 4, 1, 0, 0, 1, 1);
        vecs[8]  = mk_vec(1, 1, 0, 5, 1, 0, 0, 1, 1);
        vecs[9]  = mk_vec(0, 0, 0, 0, 0, 1, 0, 1, 1);
        vecs[10] = mk_vec(0, 0, 0, 0, 0, 0, 0, 1, 2);
        vecs[11] = mk_vec(0, 0, 1, 0, 0, 0, 0, 1, 2);
        vecs[12] = mk_vec(0, 0, 0, 0, 0, 0, 1, 1, 2);
        vecs[13] = mk_vec(0, 0, 0, 0, 1, 0, 0, 0, 2);

        i_rst = 1'b1;
        idle_inputs();
        step();
        step();
        check_output("reset", 1, 0, 0, 0, 0, 0);
        for (int l = 0; l < LANES; l++)
            check_lane("reset", l, '0, '0, '0);
        i_rst = 1'b0;

        $display("[TB] six-entry frame table");
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].valid)
                apply_stimulus(1'b1, ent_addr(vecs[i].ent), ent_w(vecs[i].ent), ent_ia(vecs[i].ent),
                               vecs[i].last, vecs[i].finish);
            else
                apply_stimulus(1'b0, '0, '0, '0, 1'b0, vecs[i].finish);
            check_output($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_start,
                         vecs[i].exp_done, vecs[i].exp_busy, 1'b0, vecs[i].exp_cnt);
            if (i == 3)
                for (int l = 0; l < 3; l++) check_lane_ent("vec3", l, l);
            if (i == 9)
                for (int l = 0; l < 3; l++) check_lane_ent("vec9", l, l + 3);
            step();
        end

        $display("[TB] four-entry frame with padding");
        send_ent(6, 1'b0);
        step();
        check_output("pad_clear", 1, 0, 0, 1, 0, 0);
        send_ent(7, 1'b0);
        step();
        send_ent(8, 1'b0);
        step();
        idle_inputs();
        step();
        pulse_finish();
        step();
        apply_stimulus(1'b1, mk_addr(1, 2, 3), 16'd5, 16'hFFF9, 1'b1, 1'b0);
        step();
        idle_inputs();
        check_output("pad_issue", 0, 1, 0, 1, 0, 1);
        check_lane("pad", 0, mk_addr(1, 2, 3), 16'd5, 16'hFFF9);
        check_lane("pad", 1, mk_addr(1, 2, 3), 16'd0, 16'd0);
        check_lane("pad", 2, mk_addr(1, 2, 3), 16'd0, 16'd0);
        step();
        pulse_finish();
        step();
        idle_inputs();
        check_output("pad_done", 0, 0, 1, 1, 0, 2);
        step();

        $display("[TB] valid held through WAIT");
        send_ent(10, 1'b0);
        step();
        send_ent(11, 1'b0);
        step();
        send_ent(12, 1'b0);
        step();
        send_ent(13, 1'b0);
        check_output("hold_issue", 0, 1, 0, 1, 0, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            check_output($sformatf("hold_wait%0d", k), 0, 0, 0, 1, 0, 1);
            check_lane_ent($sformatf("hold_wait%0d", k), 0, 10);
            check_lane_ent($sformatf("hold_wait%0d", k), 2, 12);
            step();
        end
        apply_stimulus(1'b1, ent_addr(13), ent_w(13), ent_ia(13), 1'b0, 1'b1);
        step();
        send_ent(13, 1'b0);
        check_output("hold_fill", 1, 0, 0, 1, 0, 1);
        step();
        send_ent(14, 1'b0);
        step();
        send_ent(15, 1'b1);
        step();
        idle_inputs();
        check_output("hold_issue2", 0, 1, 0, 1, 0, 1);
        check_lane_ent("hold_issue2", 0, 13);
        check_lane_ent("hold_issue2", 1, 14);
        check_lane_ent("hold_issue2", 2, 15);
        step();
        pulse_finish();
        step();
        idle_inputs();
        check_output("hold_done", 0, 0, 1, 1, 0, 2);
        step();

        $display("[TB] stray finish in FILL");
        send_ent(20, 1'b0);
        step();
        pulse_finish();
        step();
        idle_inputs();
        check_output("stray_fill", 1, 0, 0, 1, 0, 0);
        send_ent(21, 1'b0);
        step();
        send_ent(22, 1'b1);
        step();
        idle_inputs();
        check_output("stray_issue", 0, 1, 0, 1, 0, 0);
        check_lane_ent("stray", 0, 20);
        check_lane_ent("stray", 2, 22);
        step();
        pulse_finish();
        step();
        idle_inputs();
        check_output("stray_done", 0, 0, 1, 1, 0, 1);
        step();

        $display("[TB] reset in WAIT");
        send_ent(30, 1'b0);
        step();
        send_ent(31, 1'b0);
        step();
        send_ent(32, 1'b0);
        step();
        idle_inputs();
        step();
        check_output("rst_wait", 0, 0, 0, 1, 0, 1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        pulse_finish();
        check_output("rst_idle", 1, 0, 0, 0, 0, 0);
        for (int l = 0; l < LANES; l++)
            check_lane("rst_idle", l, '0, '0, '0);
        step();
        idle_inputs();
        check_output("rst_after_fin", 1, 0, 0, 0, 0, 0);
        step();
        check_output("rst_after_fin2", 1, 0, 0, 0, 0, 0);

`ifdef PE_SCHED_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        send_ent(40, 1'b1);
        step();
        idle_inputs();
        check_output("wd_issue", 0, 1, 0, 1, 0, 0);
        step();
        for (int k = 0; k < FINISH_TO; k++) begin
            check_output($sformatf("wd_wait%0d", k), 0, 0, 0, 1, 0, 1);
            step();
        end
        check_output("wd_done", 0, 0, 1, 1, 1, 1);
        step();
        check_output("wd_idle", 1, 0, 0, 0, 1, 1);
        send_ent(41, 1'b1);
        step();
        idle_inputs();
        check_output("wd_sticky", 0, 1, 0, 1, 1, 0);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check_output("wd_rst", 1, 0, 0, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
